// File: rtl/rs485_frame_parser_pkg.sv
// ----------------------------------------------------------------------------
// rs485_frame_parser_pkg
// Shared definitions for the RS-485 frame parser: FSM state encoding, the
// two sync bytes that open every frame, the error codes reported on
// err_code, and the default values for the MAX_LEN and TIMEOUT parameters.
// ----------------------------------------------------------------------------
package rs485_frame_parser_pkg;

   localparam int DEF_MAX_LEN = 16;     // payload bytes per frame (1..255)
   localparam int DEF_TIMEOUT = 4096;   // inter-byte gap limit in bclk cycles

   localparam logic [7:0] SYNC1_BYTE = 8'h55;
   localparam logic [7:0] SYNC2_BYTE = 8'hAA;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_LEN     = 2'd1,
      ERR_CHK     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   typedef enum logic [2:0] {
      S_HUNT1   = 3'd0,
      S_HUNT2   = 3'd1,
      S_ADDR    = 3'd2,
      S_LEN     = 3'd3,
      S_PAYLOAD = 3'd4,
      S_CHK     = 3'd5,
      S_DRAIN   = 3'd6
   } state_t;

   // The inter-byte gap is only policed once a frame header has been seen
   // and until its checksum byte has arrived.
   function automatic logic gap_counting(input state_t s);
      return (s == S_ADDR) || (s == S_LEN) || (s == S_PAYLOAD) || (s == S_CHK);
   endfunction

endpackage

// File: rtl/rs485_frame_parser_if.sv
// ----------------------------------------------------------------------------
// rs485_frame_parser_if
// Bundles the byte-receiver input and the BRAM-write / status outputs of
// the frame parser.
//   rx_ready   receiver status, low while a byte is being sampled
//   rx_dout    received byte, valid when rx_ready returns high
//   bram_we    BRAM write enable, one cycle per payload byte
//   bram_addr  BRAM write address
//   bram_din   BRAM write data
//   frame_done one-cycle pulse after the last write of a good frame
//   frame_err  one-cycle pulse on a rejected frame
//   err_code   reason of the most recent rejection
//   busy       parser is inside a frame (not hunting for the first sync byte)
// Modport master is the parser side, slave is the surrounding system.
// ----------------------------------------------------------------------------
interface rs485_frame_parser_if;
   import rs485_frame_parser_pkg::*;

   logic       rx_ready;
   logic [7:0] rx_dout;
   logic       bram_we;
   logic [7:0] bram_addr;
   logic [7:0] bram_din;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   modport master (
      input  rx_ready, rx_dout,
      output bram_we, bram_addr, bram_din, frame_done, frame_err, err_code, busy
   );

   modport slave (
      output rx_ready, rx_dout,
      input  bram_we, bram_addr, bram_din, frame_done, frame_err, err_code, busy
   );

endinterface

// File: rtl/rs485_byte_strobe.sv
// ----------------------------------------------------------------------------
// rs485_byte_strobe
// Turns the receiver's rx_ready level into a one-cycle byte strobe, captures
// the byte on that strobe and presents it to the FSM one cycle later. While
// the FSM is draining its buffer (hold high) a delivered byte is parked in a
// one-byte pending register and released as soon as hold drops.
//   bclk       clock
//   reset      synchronous active-high reset
//   rx_ready   receiver status (rising edge marks a new byte)
//   rx_dout    received byte, sampled on the strobe
//   hold       FSM cannot accept a byte this cycle
//   strobe     rising edge of rx_ready (used to clear the gap counter)
//   byte_valid a byte is offered to the FSM this cycle
//   byte_data  the offered byte
// ----------------------------------------------------------------------------
module rs485_byte_strobe (
   input  logic       bclk,
   input  logic       reset,
   input  logic       rx_ready,
   input  logic [7:0] rx_dout,
   input  logic       hold,
   output logic       strobe,
   output logic       byte_valid,
   output logic [7:0] byte_data
);

   logic       rx_ready_reg;
   logic       cap_valid_reg;
   logic [7:0] cap_data_reg;
   logic       pend_valid_reg;
   logic [7:0] pend_data_reg;

   // The registered copy resets high so a receiver that is idle-high when
   // reset releases does not look like a fresh byte.
   assign strobe = rx_ready & ~rx_ready_reg;

   always_ff @(posedge bclk) begin
      if (reset) begin
         rx_ready_reg   <= 1'b1;
         cap_valid_reg  <= 1'b0;
         cap_data_reg   <= 8'h00;
         pend_valid_reg <= 1'b0;
         pend_data_reg  <= 8'h00;
      end else begin
         rx_ready_reg  <= rx_ready;
         cap_valid_reg <= strobe;
         if (strobe) begin
            cap_data_reg <= rx_dout;
         end
         // A freshly captured byte goes to the pending slot if the FSM is
         // blocked, or if an older pending byte is being released this very
         // cycle (the pending byte has priority, the new one waits behind it).
         if (cap_valid_reg && (hold || pend_valid_reg)) begin
            pend_valid_reg <= 1'b1;
            pend_data_reg  <= cap_data_reg;
         end else if (!hold && pend_valid_reg) begin
            pend_valid_reg <= 1'b0;
         end
      end
   end

   assign byte_valid = ~hold & (pend_valid_reg | cap_valid_reg);
   assign byte_data  = pend_valid_reg ? pend_data_reg : cap_data_reg;

endmodule

// File: rtl/rs485_frame_parser.sv
// ----------------------------------------------------------------------------
// rs485_frame_parser
// Parses frames of the form 55 AA ADDR LEN payload[LEN] CHK arriving from a
// byte receiver. CHK is the 8-bit sum of ADDR, LEN and the payload. Payload
// bytes are staged in a local buffer and copied to an external BRAM starting
// at ADDR only once the checksum has been verified. Bad LEN, checksum
// mismatches and inter-byte gaps of TIMEOUT cycles reject the frame.
//   bclk   clock (all logic on the rising edge)
//   reset  synchronous active-high reset
//   bus    rs485_frame_parser_if.master (receiver in, BRAM/status out)
// ----------------------------------------------------------------------------
module rs485_frame_parser
   import rs485_frame_parser_pkg::*;
#(
   parameter int MAX_LEN = DEF_MAX_LEN,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 bclk,
   input  logic                 reset,
   rs485_frame_parser_if.master bus
);

   localparam int          IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int          CNT_W      = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_t state_reg, state_next;

   logic       strobe;
   logic       byte_valid;
   logic [7:0] byte_data;

   logic [7:0]       base_addr_reg;
   logic [7:0]       len_reg;
   logic [7:0]       sum_reg;
   logic [7:0]       idx_reg;
   logic [CNT_W-1:0] gap_cnt_reg;

   logic [7:0] buf_mem [0:MAX_LEN-1];
   logic [IDX_W-1:0] buf_idx;

   logic       bram_we_reg;
   logic [7:0] bram_addr_reg;
   logic [7:0] bram_din_reg;
   logic       done_stage_reg;
   logic       frame_done_reg;
   logic       frame_err_reg;
   logic [1:0] err_code_reg;

   // Output-comb results
   logic      counting;
   logic      timeout;
   logic      len_bad;
   logic      chk_ok;
   logic      last_idx;
   logic      err_fire;
   err_code_t err_code_next;
   logic      drain_we;
   logic      buf_we;
   logic      busy;

   rs485_byte_strobe u_strobe (
      .bclk       (bclk),
      .reset      (reset),
      .rx_ready   (bus.rx_ready),
      .rx_dout    (bus.rx_dout),
      .hold       (state_reg == S_DRAIN),
      .strobe     (strobe),
      .byte_valid (byte_valid),
      .byte_data  (byte_data)
   );

   assign buf_idx = idx_reg[IDX_W-1:0];

   // ---------------------------------------------------------------- state
   always_ff @(posedge bclk) begin
      if (reset) begin
         state_reg <= S_HUNT1;
      end else begin
         state_reg <= state_next;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_HUNT1: begin
            if (byte_valid && (byte_data == SYNC1_BYTE)) begin
               state_next = S_HUNT2;
            end
         end
         S_HUNT2: begin
            if (byte_valid) begin
               if (byte_data == SYNC2_BYTE) begin
                  state_next = S_ADDR;
               end else if (byte_data == SYNC1_BYTE) begin
                  state_next = S_HUNT2;
               end else begin
                  state_next = S_HUNT1;
               end
            end
         end
         S_ADDR: begin
            if (byte_valid) begin
               state_next = S_LEN;
            end else if (timeout) begin
               state_next = S_HUNT1;
            end
         end
         S_LEN: begin
            if (byte_valid) begin
               state_next = len_bad ? S_HUNT1 : S_PAYLOAD;
            end else if (timeout) begin
               state_next = S_HUNT1;
            end
         end
         S_PAYLOAD: begin
            if (byte_valid) begin
               if (last_idx) begin
                  state_next = S_CHK;
               end
            end else if (timeout) begin
               state_next = S_HUNT1;
            end
         end
         S_CHK: begin
            if (byte_valid) begin
               state_next = chk_ok ? S_DRAIN : S_HUNT1;
            end else if (timeout) begin
               state_next = S_HUNT1;
            end
         end
         S_DRAIN: begin
            if (last_idx) begin
               state_next = S_HUNT1;
            end
         end
         default: state_next = S_HUNT1;
      endcase
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      counting = gap_counting(state_reg);
      // A byte strobed or delivered in the same cycle beats the timeout.
      timeout  = counting && !strobe && !byte_valid && (gap_cnt_reg == TIMEOUT_LAST);
      len_bad  = (byte_data == 8'h00) || (byte_data > MAX_LEN_B);
      chk_ok   = (byte_data == sum_reg);
      last_idx = (idx_reg == (len_reg - 8'd1));

      err_fire      = 1'b0;
      err_code_next = ERR_NONE;
      if (timeout) begin
         err_fire      = 1'b1;
         err_code_next = ERR_TIMEOUT;
      end else if (byte_valid && (state_reg == S_LEN) && len_bad) begin
         err_fire      = 1'b1;
         err_code_next = ERR_LEN;
      end else if (byte_valid && (state_reg == S_CHK) && !chk_ok) begin
         err_fire      = 1'b1;
         err_code_next = ERR_CHK;
      end

      drain_we = (state_reg == S_DRAIN);
      buf_we   = byte_valid && (state_reg == S_PAYLOAD);
      busy     = (state_reg != S_HUNT1);
   end

   // ------------------------------------------------------- staging buffer
   // Not reset: contents are only meaningful between PAYLOAD and DRAIN.
   always_ff @(posedge bclk) begin
      if (buf_we) begin
         buf_mem[buf_idx] <= byte_data;
      end
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge bclk) begin
      if (reset) begin
         base_addr_reg  <= 8'h00;
         len_reg        <= 8'h00;
         sum_reg        <= 8'h00;
         idx_reg        <= 8'h00;
         gap_cnt_reg    <= '0;
         bram_we_reg    <= 1'b0;
         bram_addr_reg  <= 8'h00;
         bram_din_reg   <= 8'h00;
         done_stage_reg <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         err_code_reg   <= ERR_NONE;
      end else begin
         if (strobe || !counting) begin
            gap_cnt_reg <= '0;
         end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
         end

         // Buffer read is registered straight into the BRAM data port.
         bram_we_reg <= drain_we;
         if (drain_we) begin
            bram_addr_reg <= base_addr_reg + idx_reg;
            bram_din_reg  <= buf_mem[buf_idx];
         end
         // The last write appears one cycle after the last DRAIN cycle, and
         // frame_done one cycle after that, hence the two-stage pipe.
         done_stage_reg <= drain_we && last_idx;
         frame_done_reg <= done_stage_reg;

         frame_err_reg <= err_fire;
         if (err_fire) begin
            err_code_reg <= err_code_next;
         end

         if (byte_valid) begin
            case (state_reg)
               S_ADDR: begin
                  base_addr_reg <= byte_data;
                  sum_reg       <= byte_data;
               end
               S_LEN: begin
                  len_reg <= byte_data;
                  sum_reg <= sum_reg + byte_data;
                  idx_reg <= 8'h00;
               end
               S_PAYLOAD: begin
                  sum_reg <= sum_reg + byte_data;
                  idx_reg <= last_idx ? 8'h00 : idx_reg + 8'd1;
               end
               default: ;
            endcase
         end

         if (drain_we) begin
            idx_reg <= last_idx ? 8'h00 : idx_reg + 8'd1;
         end
      end
   end

   // Pulses and the write strobe are masked by reset so an abort takes
   // effect in the very cycle reset is asserted.
   assign bus.bram_we    = bram_we_reg & ~reset;
   assign bus.bram_addr  = bram_addr_reg;
   assign bus.bram_din   = bram_din_reg;
   assign bus.frame_done = frame_done_reg & ~reset;
   assign bus.frame_err  = frame_err_reg & ~reset;
   assign bus.err_code   = err_code_reg;
   assign bus.busy       = busy;

endmodule

// File: tb/tb_rs485_frame_parser.sv
module tb_rs485_frame_parser;
   import rs485_frame_parser_pkg::*;

   localparam int TB_MAX_LEN = 16;
   localparam int TB_TIMEOUT = 64;

   localparam logic [1:0] EV_WR   = 2'd0;
   localparam logic [1:0] EV_DONE = 2'd1;
   localparam logic [1:0] EV_ERR  = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic       first;
      logic [7:0] addr;
      logic [7:0] data;
      logic [1:0] code;
   } ev_t;

   logic bclk;
   logic reset;
   int   n_checks;
   int   n_errors;
   int   cyc;
   int   last_wr_cyc;
   logic test_done;

   ev_t        sb_q[$];
   logic [7:0] pl_q[$];

   rs485_frame_parser_if bus();

   rs485_frame_parser #(
      .MAX_LEN (TB_MAX_LEN),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .bclk  (bclk),
      .reset (reset),
      .bus   (bus)
   );

   initial bclk = 1'b0;
   always #5 bclk = ~bclk;

   always @(posedge bclk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_ev(input logic [1:0] kind, input logic first, input logic [7:0] addr,
                          input logic [7:0] data, input logic [1:0] code);
      ev_t e;
      e.kind  = kind;
      e.first = first;
      e.addr  = addr;
      e.data  = data;
      e.code  = code;
      sb_q.push_back(e);
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      @(posedge bclk); #1;
      bus.rx_dout  = b;
      bus.rx_ready = 1'b0;
      repeat (2) @(posedge bclk);
      #1;
      bus.rx_ready = 1'b1;
      repeat (idle) @(posedge bclk);
   endtask

   // Sends lead55 x 0x55, then AA ADDR LEN payload CHK; chk_xor corrupts CHK.
   task automatic send_frame(input logic [7:0] addr, input logic [7:0] chk_xor,
                             input int lead55, input int len_idle, input bit inject55);
      logic [7:0] len_b;
      logic [7:0] sum;
      len_b = 8'(pl_q.size());
      sum   = addr + len_b;
      foreach (pl_q[i]) sum = sum + pl_q[i];
      if (chk_xor == 8'h00) begin
         foreach (pl_q[i]) push_ev(EV_WR, (i == 0), addr + 8'(i), pl_q[i], 2'd0);
         push_ev(EV_DONE, 1'b0, 8'h00, 8'h00, 2'd0);
      end else begin
         push_ev(EV_ERR, 1'b0, 8'h00, 8'h00, 2'd2);
      end
      for (int k = 0; k < lead55; k++) send_byte(8'h55, 6);
      send_byte(8'hAA, 6);
      send_byte(addr, 6);
      send_byte(len_b, len_idle);
      foreach (pl_q[i]) send_byte(pl_q[i], 6);
      if (inject55) begin
         send_byte(sum ^ chk_xor, 3);
         send_byte(8'h55, 6);
      end else begin
         send_byte(sum ^ chk_xor, 6);
      end
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; (i < 400) && (sb_q.size() > 0); i++) @(posedge bclk);
      repeat (4) @(posedge bclk);
      check_eq(tag, sb_q.size(), 0);
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge bclk);
      check_eq({tag, "_we"},   bus.bram_we, 0);
      check_eq({tag, "_addr"}, bus.bram_addr, 0);
      check_eq({tag, "_din"},  bus.bram_din, 0);
      check_eq({tag, "_done"}, bus.frame_done, 0);
      check_eq({tag, "_err"},  bus.frame_err, 0);
      check_eq({tag, "_code"}, bus.err_code, 0);
      check_eq({tag, "_busy"}, bus.busy, 0);
   endtask

   // Scoreboard monitor: every output event pops and checks one expectation.
   always @(negedge bclk) begin
      ev_t        e;
      logic [1:0] obs;
      if (!reset && (bus.bram_we || bus.frame_done || bus.frame_err)) begin
         check_eq("single_pulse", bus.frame_done & bus.frame_err, 0);
         obs = bus.bram_we ? EV_WR : (bus.frame_done ? EV_DONE : EV_ERR);
         check_eq("sb_avail", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("event_kind", obs, e.kind);
            if (obs == EV_WR) begin
               $display("write addr=%02h data=%02h", bus.bram_addr, bus.bram_din);
               check_eq("wr_addr", bus.bram_addr, e.addr);
               check_eq("wr_data", bus.bram_din, e.data);
               if (!e.first) check_eq("wr_consecutive", cyc, last_wr_cyc + 1);
               last_wr_cyc = cyc;
            end else if (obs == EV_DONE) begin
               $display("frame_done");
               check_eq("done_after_last_wr", cyc, last_wr_cyc + 1);
            end else begin
               $display("frame_err code=%0d", bus.err_code);
               check_eq("err_code", bus.err_code, e.code);
            end
         end
      end
   end

   initial begin
      repeat (20000) @(posedge bclk);
      check_eq("watchdog", test_done, 1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      cyc          = 0;
      last_wr_cyc  = 0;
      test_done    = 1'b0;
      reset        = 1'b1;
      bus.rx_ready = 1'b1;
      bus.rx_dout  = 8'h00;
      repeat (3) @(posedge bclk);
      check_reset_state("rst");
      @(posedge bclk); #1;
      reset = 1'b0;
      repeat (3) @(posedge bclk);
      check_reset_state("idle");

      // Basic good frame: 55 AA 10 03 01 02 03 19
      pl_q = '{8'h01, 8'h02, 8'h03};
      send_frame(8'h10, 8'h00, 1, 6, 1'b0);
      wait_drain("frame_ok");

      // Same frame with CHK 0x18
      send_frame(8'h10, 8'h01, 1, 6, 1'b0);
      wait_drain("frame_badchk");

      // LEN 0 and LEN MAX_LEN+1, then a valid frame
      push_ev(EV_ERR, 1'b0, 8'h00, 8'h00, 2'd1);
      send_byte(8'h55, 6); send_byte(8'hAA, 6); send_byte(8'h00, 6); send_byte(8'h00, 6);
      wait_drain("len_zero");
      push_ev(EV_ERR, 1'b0, 8'h00, 8'h00, 2'd1);
      send_byte(8'h55, 6); send_byte(8'hAA, 6); send_byte(8'h00, 6); send_byte(8'h11, 6);
      wait_drain("len_big");
      pl_q = '{8'hC3, 8'h5A};
      send_frame(8'h40, 8'h00, 1, 6, 1'b0);
      wait_drain("after_len_err");
      @(negedge bclk);
      check_eq("err_code_hold", bus.err_code, 1);

      // Address wrap-around
      pl_q = '{8'hA1, 8'hB2, 8'hC3};
      send_frame(8'hFE, 8'h00, 1, 6, 1'b0);
      wait_drain("addr_wrap");

      // 55 55 AA prefix
      pl_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(8'h80, 8'h00, 2, 6, 1'b0);
      wait_drain("double_sync");

      // Long but legal gap after LEN, and a full MAX_LEN frame
      pl_q.delete();
      for (int k = 0; k < TB_MAX_LEN; k++) pl_q.push_back(8'(k * 7 + 3));
      send_frame(8'h20, 8'h00, 1, 50, 1'b0);
      wait_drain("gap_under_limit");

      // Timeout after LEN
      push_ev(EV_ERR, 1'b0, 8'h00, 8'h00, 2'd3);
      send_byte(8'h55, 6); send_byte(8'hAA, 6); send_byte(8'h20, 6); send_byte(8'h02, 6);
      repeat (TB_TIMEOUT + 30) @(posedge bclk);
      wait_drain("timeout");
      @(negedge bclk);
      check_eq("timeout_busy", bus.busy, 0);

      // 0x55 arriving during DRAIN must leave the FSM in HUNT2
      pl_q.delete();
      for (int k = 0; k < TB_MAX_LEN; k++) pl_q.push_back(8'(8'hF0 - k));
      send_frame(8'h60, 8'h00, 1, 6, 1'b1);
      wait_drain("drain_pending");
      @(negedge bclk);
      check_eq("hunt2_after_drain", bus.busy, 1);
      pl_q = '{8'h99};
      send_frame(8'h05, 8'h00, 0, 6, 1'b0);
      wait_drain("frame_from_pending");

      // Reset mid-PAYLOAD: nothing may come out
      send_byte(8'h55, 6); send_byte(8'hAA, 6); send_byte(8'h30, 6);
      send_byte(8'h04, 6); send_byte(8'h01, 6); send_byte(8'h02, 2);
      @(posedge bclk); #1;
      reset = 1'b1;
      repeat (2) @(posedge bclk);
      check_reset_state("midrst");
      @(posedge bclk); #1;
      reset = 1'b0;
      repeat (30) @(posedge bclk);
      check_reset_state("after_midrst");

      pl_q = '{8'h0A, 8'h0B};
      send_frame(8'h33, 8'h00, 1, 6, 1'b0);
      wait_drain("final_frame");

      test_done = 1'b1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
